mux_scan_serializer: RTL and testbench

Parallel-to-serial front end for the 16:1 bit-select multiplexer. It accepts a 16-bit word over a valid/ready handshake, holds it on the mux data inputs, steps the 4-bit select through all 16 positions, and registers the returned mux bit as a framed serial stream with first/last markers. The mux stays outside this block. The block drives the mux `in`/`sel` and consumes its `out`.

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/scan_sel_counter.sv | 38 +++
 rtl/mux_scan_serializer.sv | 99 +++++++++
 tb/tb_mux_scan_serializer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan serializer.
package mux_scan_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEL_W  = 4;

    localparam logic [SEL_W-1:0] LAST_IDX = 4'd15;

    typedef enum logic {
        StIdle = 1'b0,
        StScan = 1'b1
    } state_e;

    // Select seen by the mux for a given bit index; MSB-first scans walk the word backwards.
    function automatic logic [SEL_W-1:0] scan_sel(input logic [SEL_W-1:0] cnt,
                                                  input bit msb_first);
        return msb_first ? ~cnt : cnt;
    endfunction

endpackage

// File: rtl/scan_sel_counter.sv
// Bit-index counter for the scan: clear on word accept, advance on each unstalled scan edge.
module scan_sel_counter
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             term
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    // Clear wins over advance; 15 -> 0 is plain overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + SEL_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == LAST_IDX);

endmodule

// File: rtl/mux_scan_serializer.sv
// Holds a 16-bit word on an external 16:1 mux, steps its select, and registers the
// returned bit as a framed serial stream.
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] word_o,
    output logic [SEL_W-1:0]  sel_o,
    input  logic              mux_i,
    input  logic              stall,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy
);

    state_e            state_q;
    state_e            state_d;
    logic [WORD_W-1:0] word_q;
    logic [SEL_W-1:0]  cnt;
    logic              term;
    logic              scan_step;
    logic              accept;
    logic              ser_out_q;
    logic              ser_valid_q;
    logic              ser_first_q;
    logic              ser_last_q;

    // A sample is taken on every SCAN edge that is not held by back-pressure.
    assign scan_step  = (state_q == StScan) && !stall;
    // Ready on the final-bit edge lets the next word follow with no bubble.
    assign load_ready = (state_q == StIdle) || (scan_step && term);
    assign accept     = load_valid && load_ready;

    scan_sel_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (scan_step),
        .cnt   (cnt),
        .term  (term)
    );

    // Next state: enter SCAN on accept, leave after the last bit unless refilled.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StScan;
        end else if (scan_step && term) begin
            state_d = StIdle;
        end
    end

    // State and captured word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q <= load_data;
            end
        end
    end

    // Serial output stage: the old word's bit is sampled even on a refill edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            ser_valid_q <= scan_step;
            ser_first_q <= scan_step && (cnt == '0);
            ser_last_q  <= scan_step && term;
            if (scan_step) begin
                ser_out_q <= mux_i;
            end
        end
    end

    assign word_o    = word_q;
    assign sel_o     = scan_sel(cnt, MSB_FIRST);
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign busy      = (state_q == StScan);

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: LSB-first and MSB-first instances share one stimulus
// stream; a monitor checks both against a word-level model and per-instance scoreboards.
module tb_mux_scan_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        stall = 1'b0;
    logic        done = 1'b0;
    logic        drv_timeout = 1'b0;

    logic        ready_l, ready_m;
    logic [15:0] word_l, word_m;
    logic [3:0]  sel_l, sel_m;
    logic        mux_l, mux_m;
    logic        ser_out_l, ser_out_m;
    logic        ser_valid_l, ser_valid_m;
    logic        ser_first_l, ser_first_m;
    logic        ser_last_l, ser_last_m;
    logic        busy_l, busy_m;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Behavioural 16:1 muxes in the loop.
    assign mux_l = word_l[sel_l];
    assign mux_m = word_m[sel_m];

    mux_scan_serializer #(.MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .load_data  (load_data),
        .word_o     (word_l),
        .sel_o      (sel_l),
        .mux_i      (mux_l),
        .stall      (stall),
        .ser_out    (ser_out_l),
        .ser_valid  (ser_valid_l),
        .ser_first  (ser_first_l),
        .ser_last   (ser_last_l),
        .busy       (busy_l)
    );

    mux_scan_serializer #(.MSB_FIRST(1'b1)) u_dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .load_data  (load_data),
        .word_o     (word_m),
        .sel_o      (sel_m),
        .mux_i      (mux_m),
        .stall      (stall),
        .ser_out    (ser_out_m),
        .ser_valid  (ser_valid_m),
        .ser_first  (ser_first_m),
        .ser_last   (ser_last_m),
        .busy       (busy_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; returns just after the accepting edge.
    task automatic load_word(input logic [15:0] w);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        while (!ready_l && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_l) drv_timeout = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    // Driver
    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        // Single words, both scan orders in parallel.
        load_word(16'hA5C3);
        repeat (20) step();
        load_word(16'h8001);
        repeat (20) step();
        // Back-to-back with load_valid held high.
        load_word(16'hFFFF);
        load_word(16'h0000);
        repeat (20) step();
        // Stalls while the bit index is 3 and then 8.
        load_word(16'h0F0F);
        repeat (3) step();
        stall = 1'b1;
        step();
        stall = 1'b0;
        repeat (5) step();
        stall = 1'b1;
        step();
        stall = 1'b0;
        repeat (12) step();
        // Load offered mid-word must be ignored.
        load_word(16'h5A5A);
        repeat (5) step();
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_valid = 1'b0;
        repeat (14) step();
        // Asynchronous reset with the index at 7.
        load_word(16'hC0DE);
        repeat (7) step();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) step();
        // Random traffic with random back-pressure.
        repeat (400) begin
            stall      = ($urandom_range(0, 3) == 0);
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 16'($urandom);
            step();
        end
        stall      = 1'b0;
        load_valid = 1'b0;
        repeat (20) step();
        done = 1'b1;
    end

    // Monitor and word-level model
    initial begin
        int          rem;
        int          idx;
        logic        exp_valid;
        logic        exp_ready;
        logic        next_valid;
        logic [15:0] exp_word;
        logic [2:0]  e;
        logic [2:0]  q_l[$];
        logic [2:0]  q_m[$];
        rem       = 0;
        exp_valid = 1'b0;
        exp_word  = '0;
        while (!done) begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                check("rst_word_l", 32'(word_l), 32'h0);
                check("rst_word_m", 32'(word_m), 32'h0);
                check("rst_sel_l", 32'(sel_l), 32'd0);
                check("rst_sel_m", 32'(sel_m), 32'd15);
                check("rst_ser_l", 32'({ser_out_l, ser_valid_l, ser_first_l, ser_last_l}), 32'h0);
                check("rst_ser_m", 32'({ser_out_m, ser_valid_m, ser_first_m, ser_last_m}), 32'h0);
                check("rst_busy_l", 32'(busy_l), 32'h0);
                check("rst_busy_m", 32'(busy_m), 32'h0);
                q_l.delete();
                q_m.delete();
                rem       = 0;
                exp_valid = 1'b0;
                exp_word  = '0;
            end else begin
                exp_ready = (rem == 0) || (rem == 1 && !stall);
                check("load_ready_l", 32'(ready_l), 32'(exp_ready));
                check("load_ready_m", 32'(ready_m), 32'(exp_ready));
                check("busy_l", 32'(busy_l), 32'(rem != 0));
                check("busy_m", 32'(busy_m), 32'(rem != 0));
                check("word_l", 32'(word_l), 32'(exp_word));
                check("word_m", 32'(word_m), 32'(exp_word));
                idx = (rem == 0) ? 0 : 16 - rem;
                check("sel_l", 32'(sel_l), 32'(idx));
                check("sel_m", 32'(sel_m), 32'(15 - idx));
                check("ser_valid_l", 32'(ser_valid_l), 32'(exp_valid));
                check("ser_valid_m", 32'(ser_valid_m), 32'(exp_valid));
                if (ser_valid_l) begin
                    check("ser_pending_l", 32'(q_l.size() != 0), 32'h1);
                    if (q_l.size() != 0) begin
                        e = q_l.pop_front();
                        check("ser_bits_l", 32'({ser_out_l, ser_first_l, ser_last_l}), 32'(e));
                    end
                end
                if (ser_valid_m) begin
                    check("ser_pending_m", 32'(q_m.size() != 0), 32'h1);
                    if (q_m.size() != 0) begin
                        e = q_m.pop_front();
                        check("ser_bits_m", 32'({ser_out_m, ser_first_m, ser_last_m}), 32'(e));
                    end
                end
                // Predict the coming edge from the inputs now stable.
                next_valid = (rem != 0) && !stall;
                if (next_valid) rem--;
                if (load_valid && exp_ready) begin
                    rem      = 16;
                    exp_word = load_data;
                    for (int k = 0; k < 16; k++) begin
                        q_l.push_back({load_data[k], k == 0, k == 15});
                        q_m.push_back({load_data[15-k], k == 0, k == 15});
                    end
                end
                exp_valid = next_valid;
            end
        end
        check("drained_l", 32'(q_l.size()), 32'd0);
        check("drained_m", 32'(q_m.size()), 32'd0);
        check("driver_timeout", 32'(drv_timeout), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
